pll_acq_ctrl: RTL and testbench

- Acquisition/lock sequencer for the shared dblcordicpll instance.
- Loads the nominal phase step (drives i_ld/i_step) and gear-shifts loop bandwidth by stepping i_lgcoeff from wide (LG_START) to narrow (LG_FINAL) as the phase error settles.
- Declares lock, monitors the PLL's o_err, and re-launches acquisition on loss of lock.
- Sits between the system control registers and the PLL; the PLL's i_ce strobe is shared.

---
 rtl/pll_acq_pkg.sv | 23 ++
 rtl/err_peak_window.sv | 42 ++++
 rtl/pll_acq_ctrl.sv | 153 +++++++++++++++
 tb/tb_pll_acq_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pll_acq_pkg.sv
// Shared definitions for the PLL acquisition sequencer: state encodings,
// gear (lgcoeff) width and the saturating |err| helper.
package pll_acq_pkg;

    localparam int LG_W  = 5;
    localparam int ABS_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_ACQUIRE = 3'd2;
    localparam logic [2:0] ST_LOCKED  = 3'd3;

    // |v| with the most negative code folded onto the most positive one
    function automatic logic [ABS_W-1:0] sat_abs(input logic signed [ABS_W-1:0] v);
        if (v == {1'b1, {(ABS_W-1){1'b0}}})
            return {1'b0, {(ABS_W-1){1'b1}}};
        else if (v[ABS_W-1])
            return ABS_W'(-v);
        else
            return v;
    endfunction

endpackage

// File: rtl/err_peak_window.sv
// Tracks the peak |err| over a window of 2^DWELL_LG ce strobes. The done
// pulse and peak are combinational so the caller decides on the cycle of
// the last strobe using a peak that already includes that sample.
module err_peak_window
    import pll_acq_pkg::*;
#(
    parameter int DWELL_LG = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic [ABS_W-1:0] i_err,
    input  logic             i_clear,
    output logic             o_window_done,
    output logic [ABS_W-1:0] o_peak
);

    logic [DWELL_LG-1:0] r_cnt;
    logic [ABS_W-1:0]    r_peak;
    logic [ABS_W-1:0]    w_abs;
    logic                w_take;

    assign w_abs         = sat_abs($signed(i_err));
    assign w_take        = i_ce && !i_clear;
    assign o_peak        = (w_take && (w_abs > r_peak)) ? w_abs : r_peak;
    assign o_window_done = w_take && (r_cnt == '1);

    // Sample counter wraps naturally at window end; clear discards the window
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_peak <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_peak <= '0;
        end else if (i_ce) begin
            r_cnt  <= r_cnt + 1'b1;
            r_peak <= o_window_done ? '0 : o_peak;
        end
    end

endmodule

// File: rtl/pll_acq_ctrl.sv
// Acquisition/lock sequencer for the shared dblcordicpll: loads the nominal
// step, gear-shifts lgcoeff from LG_START to LG_FINAL as windows pass,
// declares lock and re-acquires when the error blows up.
// Optional: define PLL_ACQ_CTRL_BACKOFF_EN to widen the bandwidth by one
// gear after STALL_WINDOWS consecutive failing windows in ACQUIRE.
module pll_acq_ctrl
    import pll_acq_pkg::*;
#(
    parameter int              STEP_W        = 31,
    parameter int              ERR_W         = 16,
    parameter logic [LG_W-1:0] LG_START      = 5'd4,
    parameter logic [LG_W-1:0] LG_FINAL      = 5'd12,
    parameter int              DWELL_LG      = 10,
    parameter logic [ERR_W-1:0] LOCK_THRESH   = 16'd512,
    parameter logic [ERR_W-1:0] UNLOCK_THRESH = 16'd4096,
    parameter int              STALL_WINDOWS = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [STEP_W-1:0] i_nominal_step,
    input  logic              i_ce,
    input  logic [ERR_W-1:0]  i_err,
    output logic              o_ld,
    output logic [STEP_W-1:0] o_step,
    output logic [LG_W-1:0]   o_lgcoeff,
    output logic              o_locked,
    output logic              o_lost,
    output logic [2:0]        o_state
);

    if (LG_FINAL < LG_START) begin : g_bad_gears
        $error("LG_FINAL must be >= LG_START");
    end
    if (STALL_WINDOWS < 1) begin : g_bad_stall
        $error("STALL_WINDOWS must be >= 1");
    end

    logic [2:0]        r_state;
    logic              r_ld;
    logic [STEP_W-1:0] r_step;
    logic [LG_W-1:0]   r_lg;
    logic              r_locked;
    logic              r_lost;

    logic              w_clear;
    logic              w_done;
    logic [ABS_W-1:0]  w_peak;
    logic              w_pass;
    logic              w_backoff;

    // Window only runs while tracking; LOAD, IDLE and a dropping enable
    // all discard it (and LOAD drops any coincident strobe)
    assign w_clear = !i_enable || ((r_state != ST_ACQUIRE) && (r_state != ST_LOCKED));
    assign w_pass  = (w_peak < LOCK_THRESH);

    err_peak_window #(
        .DWELL_LG (DWELL_LG)
    ) u_win (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_ce          (i_ce),
        .i_err         (i_err),
        .i_clear       (w_clear),
        .o_window_done (w_done),
        .o_peak        (w_peak)
    );

`ifdef PLL_ACQ_CTRL_BACKOFF_EN
    localparam int STALL_W = $clog2(STALL_WINDOWS + 1);
    logic [STALL_W-1:0] r_stall;
    logic               w_stall_hit;

    assign w_stall_hit = (r_stall == STALL_W'(STALL_WINDOWS - 1));
    assign w_backoff   = w_stall_hit;

    // Consecutive failing windows at the current gear; restarts on pass,
    // on a gear change (including a floored back-off) and outside ACQUIRE
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_stall <= '0;
        else if (!i_enable || (r_state != ST_ACQUIRE))
            r_stall <= '0;
        else if (w_done)
            r_stall <= (w_pass || w_stall_hit) ? '0 : r_stall + 1'b1;
    end
`else
    assign w_backoff = 1'b0;
`endif

    // Sequencer FSM; enable drop outranks any window decision
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_ld     <= 1'b0;
            r_step   <= '0;
            r_lg     <= LG_START;
            r_locked <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_ld   <= 1'b0;
            r_lost <= 1'b0;
            if (!i_enable) begin
                r_state  <= ST_IDLE;
                r_lg     <= LG_START;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_LOAD;
                        r_lg    <= LG_START;
                    end
                    ST_LOAD: begin
                        r_ld    <= 1'b1;
                        r_step  <= i_nominal_step;
                        r_lg    <= LG_START;
                        r_state <= ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (w_done) begin
                            if (w_pass) begin
                                if (r_lg < LG_FINAL) begin
                                    r_lg <= r_lg + 1'b1;
                                end else begin
                                    r_state  <= ST_LOCKED;
                                    r_locked <= 1'b1;
                                end
                            end else if (w_backoff && (r_lg > LG_START)) begin
                                r_lg <= r_lg - 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_done && (w_peak >= UNLOCK_THRESH)) begin
                            r_locked <= 1'b0;
                            r_lost   <= 1'b1;
                            r_state  <= ST_LOAD;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_ld      = r_ld;
    assign o_step    = r_step;
    assign o_lgcoeff = r_lg;
    assign o_locked  = r_locked;
    assign o_lost    = r_lost;
    assign o_state   = r_state;

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// Directed bench for pll_acq_ctrl with 16-sample windows and ce every 4th
// cycle. Define PLL_ACQ_CTRL_BACKOFF_EN here too to check the back-off build.
module tb_pll_acq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [30:0] nstep;
    logic        ce;
    logic [15:0] err;
    logic        ld;
    logic [30:0] step;
    logic [4:0]  lg;
    logic        locked;
    logic        lost;
    logic [2:0]  state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_acq_ctrl #(
        .STEP_W        (31),
        .ERR_W         (16),
        .LG_START      (5'd4),
        .LG_FINAL      (5'd12),
        .DWELL_LG      (4),
        .LOCK_THRESH   (16'd512),
        .UNLOCK_THRESH (16'd4096),
        .STALL_WINDOWS (8)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_nominal_step (nstep),
        .i_ce           (ce),
        .i_err          (err),
        .o_ld           (ld),
        .o_step         (step),
        .o_lgcoeff      (lg),
        .o_locked       (locked),
        .o_lost         (lost),
        .o_state        (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ld"},     32'(ld),     32'd0);
        chk({tag, ".step"},   32'(step),   32'd0);
        chk({tag, ".lg"},     32'(lg),     32'd4);
        chk({tag, ".locked"}, 32'(locked), 32'd0);
        chk({tag, ".lost"},   32'(lost),   32'd0);
        chk({tag, ".state"},  32'(state),  32'd0);
    endtask

    // one ce strobe every 4th cycle; returns just after the edge that took it
    task automatic strobe(input logic [15:0] e);
        err = e;
        ce  = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
    endtask

    task automatic windows(input int n, input logic [15:0] e);
        repeat (n * 16) strobe(e);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; nstep = '0; ce = 1'b0; err = '0;

        // 1: reset, then enable and load
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1; nstep = 31'h0147AE14;
        @(negedge clk);
        chk("load.state", 32'(state), 32'd1);
        chk("load.ld_early", 32'(ld), 32'd0);
        @(negedge clk);
        chk("acq.ld", 32'(ld), 32'd1);
        chk("acq.step", 32'(step), 32'h0147AE14);
        chk("acq.lg", 32'(lg), 32'd4);
        chk("acq.state", 32'(state), 32'd2);
        @(negedge clk);
        chk("acq.ld_pulse", 32'(ld), 32'd0);

        // 2: small error walks the gears up to lock
        for (int g = 5; g <= 12; g++) begin
            windows(1, 16'd100);
            chk($sformatf("gear%0d", g), 32'(lg), 32'(g));
            chk("gear.unlocked", 32'(locked), 32'd0);
        end
        windows(1, 16'd100);
        chk("lock.locked", 32'(locked), 32'd1);
        chk("lock.state", 32'(state), 32'd3);
        chk("lock.lg", 32'(lg), 32'd12);

        // 3: one saturated sample in a locked window forces re-acquire
        repeat (4) strobe(16'd100);
        strobe(16'h8000);
        repeat (10) strobe(16'd100);
        chk("lk.mid_locked", 32'(locked), 32'd1);
        strobe(16'd100);
        chk("lost.pulse", 32'(lost), 32'd1);
        chk("lost.locked", 32'(locked), 32'd0);
        chk("lost.state", 32'(state), 32'd1);
        @(negedge clk);
        chk("lost.pulse_end", 32'(lost), 32'd0);
        chk("relo.ld", 32'(ld), 32'd1);
        chk("relo.lg", 32'(lg), 32'd4);
        chk("relo.state", 32'(state), 32'd2);

        // 4: failing windows hold (or back off) the gear
        windows(3, 16'd100);
        chk("g7", 32'(lg), 32'd7);
        windows(7, 16'd600);
        chk("fail7.lg", 32'(lg), 32'd7);
        windows(1, 16'd600);
`ifdef PLL_ACQ_CTRL_BACKOFF_EN
        chk("fail8.lg", 32'(lg), 32'd6);
        windows(8, 16'd600);
        chk("back5", 32'(lg), 32'd5);
        windows(8, 16'd600);
        chk("back4", 32'(lg), 32'd4);
        windows(8, 16'd600);
        chk("floor4", 32'(lg), 32'd4);
`else
        chk("fail8.lg", 32'(lg), 32'd7);
`endif
        chk("fail.state", 32'(state), 32'd2);

        // 5: enable drop coincident with a passing window end
        repeat (15) strobe(16'd100);
        err = 16'd100; ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1; en = 1'b0;
        @(negedge clk);
        ce = 1'b0;
        chk("drop.state", 32'(state), 32'd0);
        chk("drop.lg", 32'(lg), 32'd4);
        chk("drop.lost", 32'(lost), 32'd0);
        chk("drop.locked", 32'(locked), 32'd0);
        @(negedge clk);
        chk("idle.state", 32'(state), 32'd0);

        // 6: asynchronous reset mid-ACQUIRE, then LOAD with a dropped strobe
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("re.state", 32'(state), 32'd2);
        windows(1, 16'd100);
        chk("re.g5", 32'(lg), 32'd5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post.state", 32'(state), 32'd1);
        ce = 1'b1; err = 16'd100;
        @(negedge clk);
        ce = 1'b0;
        chk("post.ld", 32'(ld), 32'd1);
        chk("post.step", 32'(step), 32'h0147AE14);
        repeat (15) strobe(16'd100);
        chk("drop_ce.lg4", 32'(lg), 32'd4);
        strobe(16'd100);
        chk("drop_ce.lg5", 32'(lg), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
